sort4_sequencer: RTL
====================

# sort4_sequencer

Sequential 4-element sorter that time-shares a single `comparator` instance across the five compare-exchange steps of a 4-input Batcher odd-even merge sort. It replaces the fully parallel merge network where area matters more than throughput. Operands arrive as a serial valid/ready stream and leave as a serial stream in ascending order. It sits between the sensor/message ingest stage and the V2V priority logic.

## Interface
- `WIDTH`, default 8: operand width in bits; unsigned compare.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: `in_data` holds a valid operand.
- `in_ready`  out  1: block accepts an operand this cycle.
- `in_data`  in  WIDTH: operand.
- `out_valid`  out  1: `out_data` holds a sorted result.
- `out_ready`  in  1: downstream accepts a result this cycle.
- `out_data`  out  WIDTH: sorted result, smallest first.
- `out_last`  out  1: high with the 4th (largest) result.
- `busy`  out  1: high in SORT and DRAIN.

## Operation
- Storage is four WIDTH-bit registers `r0..r3` plus a 2-bit index `idx`.
- The FSM has three states: LOAD, SORT, DRAIN.
- **LOAD**
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) writes `in_data` to `r[idx]` and increments `idx`.
  - On the 4th handshake (`idx`==3), go to SORT with `step`=0 and `idx`=0.
- **SORT**
  - `in_ready`=0. `step` is a 3-bit counter, 0..4.
  - Each cycle, one compare-exchange: the comparator's A/B take the pair, L is written to the lower index and H to the higher.
  - Schedule: step0 (r0,r1); step1 (r2,r3); step2 (r0,r2); step3 (r1,r3); step4 (r1,r2).
  - After step4 is written, go to DRAIN.
- **DRAIN**
  - `out_valid`=1, `out_data`=`r[idx]`, `out_last`=(`idx`==3).
  - Each handshake (`out_valid`&`out_ready`) increments `idx`.
  - The handshake with `out_last` returns to LOAD with `idx`=0.
- Ties: equal operands may be exchanged or not. Output values are identical either way.
- No new batch is accepted during SORT or DRAIN. There is no input/output overlap.

## Timing
- Reset values:
  - FSM state: LOAD.
  - Registers: `idx`=0, `step`=0, `r0..r3`=0.
  - Outputs: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0.
- All outputs are decoded from registered state only. There is no combinational path from `in_valid`/`out_ready` to any output.
- If the 4th input handshake occurs at edge E:
  - SORT occupies the cycles after edges E..E+4.
  - `out_valid` rises after edge E+5 (5-cycle sort latency).
- Throughput with `in_valid`/`out_ready` held high: one batch per 13 cycles (4 load + 5 sort + 4 drain).
- Output backpressure: while `out_ready`=0, `out_data`/`out_last` hold stable and `out_valid` stays high.
- Input gaps: `in_valid` gaps in LOAD simply stall `idx`.
- Reset mid-operation: asserting `rst_n`=0 in any state returns immediately (asynchronously) to the reset values. A partial batch is discarded.

## Structure
- Shared package: state encoding constants (LOAD, SORT, DRAIN) and the 5-entry step schedule (index pairs). The parallel merge variants reuse the same schedule.
- One sub-module: the existing `comparator` (ports A, B, L, H), instantiated once with `.WIDTH(WIDTH)`.
- Muxes select A/B from `r0..r3` by `step`.
- Write-back demux targets the scheduled index pair.

## Test plan
- Reset then idle:
  - Stimulus: release `rst_n`, drive nothing.
  - Required: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0 for 20 cycles.
- Reverse-order batch:
  - Stimulus: feed 8'h40, 8'h30, 8'h20, 8'h10 back-to-back with `out_ready`=1.
  - Required: `out_valid` rises 5 cycles after the 4th accept; outputs are 10, 20, 30, 40; `out_last` only with 40.
- Duplicates and extremes:
  - Stimulus: feed FF, 00, FF, 00.
  - Required: outputs 00, 00, FF, FF.
- Backpressure:
  - Stimulus: batch 05, 03, 07, 01; hold `out_ready`=0 for 6 cycles in DRAIN, then toggle it every cycle.
  - Required: `out_data` stable at 01 while stalled; outputs 01, 03, 05, 07 with no loss or duplicate.
- Input gaps and back-to-back batches:
  - Stimulus: feed 09, 02, 06, 04 with `in_valid` dropping between words.
  - Required: outputs 02, 04, 06, 09; `in_ready`=0 from the 4th accept until the `out_last` handshake; the next batch is accepted the cycle after.
- Reset mid-SORT:
  - Stimulus: pull `rst_n` low at SORT step 2; then release and feed 03, 01, 04, 02.
  - Required: all outputs return to reset values immediately; the new batch outputs 01, 02, 03, 04.

Source files
------------

// File: rtl/sort4_sequencer_pkg.sv
// Shared definitions for the 4-input odd-even merge sorters: FSM encoding and
// the compare-exchange schedule, which the parallel variants reuse.
package sort4_sequencer_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] lo;
        logic [1:0] hi;
    } stepPair_t;

    localparam int NUM_STEPS = 5;

    // Batcher 4-input network: two 2-sorters, then the 2x2 merge.
    function automatic stepPair_t stepPair(input logic [2:0] step);
        stepPair_t p;
        case (step)
            3'd0:    p = '{lo: 2'd0, hi: 2'd1};
            3'd1:    p = '{lo: 2'd2, hi: 2'd3};
            3'd2:    p = '{lo: 2'd0, hi: 2'd2};
            3'd3:    p = '{lo: 2'd1, hi: 2'd3};
            default: p = '{lo: 2'd1, hi: 2'd2};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sort4_sequencer_comparator.sv
// Unsigned compare-exchange: L gets the smaller operand, H the larger.
module comparator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] L,
    output logic [WIDTH-1:0] H
);

    logic aLeB;

    assign aLeB = (A <= B);
    assign L    = aLeB ? A : B;
    assign H    = aLeB ? B : A;

endmodule

// File: rtl/sort4_sequencer.sv
// Serial-in/serial-out 4-element sorter sharing one comparator across the five
// compare-exchange steps. Outputs decode from registered state only.
module sort4_sequencer
    import sort4_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    state_t                state, nextState;
    logic [3:0][WIDTH-1:0] r;
    logic [1:0]            idx;
    logic [2:0]            step;
    stepPair_t             pair;
    logic [WIDTH-1:0]      cmpA, cmpB, cmpL, cmpH;

    assign pair = stepPair(step);
    assign cmpA = r[pair.lo];
    assign cmpB = r[pair.hi];

    comparator #(.WIDTH(WIDTH)) uCmp (
        .A (cmpA),
        .B (cmpB),
        .L (cmpL),
        .H (cmpH)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            LOAD:    if (in_valid && idx == 2'd3)  nextState = SORT;
            SORT:    if (step == 3'(NUM_STEPS-1))   nextState = DRAIN;
            DRAIN:   if (out_ready && idx == 2'd3) nextState = LOAD;
            default: nextState = LOAD;
        endcase
    end

    // idx wraps 3->0 naturally, which gives idx=0 entering SORT and LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            idx  <= '0;
            step <= '0;
        end else begin
            case (state)
                LOAD: begin
                    step <= '0;
                    if (in_valid) begin
                        r[idx] <= in_data;
                        idx    <= idx + 2'd1;
                    end
                end
                SORT: begin
                    r[pair.lo] <= cmpL;
                    r[pair.hi] <= cmpH;
                    step       <= (step == 3'(NUM_STEPS-1)) ? 3'd0 : step + 3'd1;
                end
                DRAIN: if (out_ready) idx <= idx + 2'd1;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (idx == 2'd3);
    assign out_data  = (state == DRAIN) ? r[idx] : '0;
    assign busy      = (state != LOAD);

endmodule
